uart_rx_stream: RTL
===================

// Module: uart_rx_stream
// PURPOSE
//   Standalone 16x-oversampled UART receiver with majority-vote bit sampling, optional parity,
//   and a small show-ahead receive FIFO with a valid/ready output port. Serves as the receive
//   end of the team's UART serial link, paired with the existing UART transmitter on the far side.
//   Sits between the asynchronous rx_in pin and a synchronous byte consumer in the rxclk domain.
// PARAMETERS
//   DATA_BITS   8   data bits per frame (5..8), sent LSB first
//   PARITY      0   0 = none, 1 = even, 2 = odd
//   FIFO_DEPTH  4   receive FIFO entries; power of 2, at least 2
// PORTS
//   rxclk       in   1               clock, 16x baud rate
//   reset       in   1               asynchronous, active-high
//   rx_enable   in   1               receiver enable; low aborts any frame in progress
//   rx_in       in   1               serial line, asynchronous, idle high
//   m_data      out  DATA_BITS       FIFO head byte
//   m_valid     out  1               FIFO not empty
//   m_ready     in   1               consumer pop; pop occurs when m_valid && m_ready
//   fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently held
//   frame_err   out  1               1-cycle pulse: stop bit sampled 0
//   parity_err  out  1               1-cycle pulse: parity mismatch
//   break_det   out  1               1-cycle pulse: all data bits 0, parity 0 (if enabled), and stop 0
//   overrun     out  1               sticky: a good byte was dropped because the FIFO was full
//   clr_overrun in   1               synchronous clear of overrun; set wins if both occur in the same cycle
// BEHAVIOUR
//   Reset: sync flops = 1, FSM = IDLE, counters = 0, FIFO empty, m_data = 0, m_valid = 0,
//     fifo_level = 0, all error outputs = 0. Reset mid-frame discards the partial frame.
//   rx_in passes through a 2-flop synchronizer (rx_s); all decisions use rx_s.
//   scnt: 4-bit sample counter, wraps 15 -> 0. bcnt counts data bits 0..DATA_BITS-1.
//   Bit value = majority of rx_s at scnt = 7, 8, 9, decided at scnt = 9.
//   FSM:
//     IDLE   : rx_enable && rx_s == 0 -> START, scnt = 1.
//     START  : at scnt = 9, majority 1 -> IDLE (glitch, no error); else continue.
//              At scnt = 15 -> DATA, bcnt = 0.
//     DATA   : at scnt = 9, shift the decided bit into shreg[bcnt].
//              At scnt = 15: if bcnt == DATA_BITS-1 -> PARITY (or STOP when PARITY = 0);
//              else bcnt increments.
//     PARITY : at scnt = 9, compare the bit against even/odd parity of shreg; latch the mismatch.
//              At scnt = 15 -> STOP.
//     STOP   : at scnt = 9, go to IDLE in the same cycle, so the next start bit is accepted early.
//              stop = 0          -> frame_err pulse (plus break_det if its condition holds); no push.
//              stop = 1, mismatch -> parity_err pulse; no push.
//              stop = 1, no mismatch -> push shreg.
//   rx_enable low in any state -> IDLE next cycle. FIFO contents and overrun are retained.
//   Error pulses assert on the cycle after the STOP decision; they are mutually exclusive
//     except that break_det accompanies frame_err.
//   FIFO:
//     Show-ahead: m_data is the head entry while m_valid = 1.
//     A pushed byte appears on m_valid/m_data on the next cycle (1-cycle push latency).
//     Push when full without a same-cycle pop -> byte dropped, overrun set.
//     Push with a same-cycle pop when full -> both occur; level unchanged.
//     Pop when empty -> ignored.
//     Pointers wrap modulo FIFO_DEPTH. fifo_level is updated registered, with push and pop.
// TESTING
//   1. Defaults: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one push; m_valid = 1,
//      m_data = 8'hA5, fifo_level = 1; m_ready pulse -> m_valid = 0, level = 0.
//   2. rx_in low for 4 cycles, then high -> START aborts to IDLE; no push, no error pulses.
//   3. 0x3C with stop bit = 0 -> frame_err pulse, FIFO unchanged. All-zero frame with stop = 0
//      -> frame_err and break_det in the same cycle.
//   4. PARITY = 1: send 0x01 with parity bit 0 -> parity_err pulse, no push.
//      Send 0x01 with parity bit 1 -> 0x01 pushed.
//   5. m_ready = 0; send 0x10, 0x11, 0x12, 0x13, 0x14 -> level = 4, overrun = 1,
//      pops yield 10, 11, 12, 13. clr_overrun -> overrun = 0.
//   6. Drop rx_enable during data bit 3, then reassert and send 0x5A -> only 0x5A pushed.
//      Assert reset mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/uart_rx_stream.sv
// uart_rx_stream
//   16x-oversampled UART receiver. The asynchronous rx_in line is synchronised,
//   each bit is decided by a majority vote of three mid-bit samples, an optional
//   parity bit is checked, and good bytes are written into a small show-ahead
//   FIFO that is read through a valid/ready port.
//
// Ports
//   rxclk        clock, 16x the baud rate
//   reset        asynchronous, active-high
//   rx_enable    receiver enable; low returns the receiver to idle
//   rx_in        serial line, idle high, asynchronous to rxclk
//   m_data       FIFO head byte (0 while the FIFO is empty)
//   m_valid      FIFO not empty
//   m_ready      consumer accepts the head byte when m_valid is high
//   fifo_level   number of bytes held in the FIFO
//   frame_err    1-cycle pulse: stop bit sampled low
//   parity_err   1-cycle pulse: parity mismatch with a good stop bit
//   break_det    1-cycle pulse alongside frame_err when the whole frame was low
//   overrun      sticky: a good byte was dropped because the FIFO was full
//   clr_overrun  clears overrun; a same-cycle overrun event takes priority
module uart_rx_stream #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          rxclk,
    input  logic                          reset,
    input  logic                          rx_enable,
    input  logic                          rx_in,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          break_det,
    output logic                          overrun,
    input  logic                          clr_overrun
);

    localparam int   BW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int   AW      = $clog2(FIFO_DEPTH);
    localparam int   LW      = AW + 1;
    localparam logic PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Receiver state
    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    state_t               state_reg;
    logic [3:0]           scnt_reg;
    logic [BW-1:0]        bcnt_reg;
    logic                 samp7_reg;
    logic                 samp8_reg;
    logic [DATA_BITS-1:0] shreg_reg;
    logic                 par_bit_reg;
    logic                 mismatch_reg;
    logic                 frame_err_reg;
    logic                 parity_err_reg;
    logic                 break_det_reg;

    // FIFO state
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [LW-1:0]        level_reg;
    logic                 overrun_reg;

    logic bit_maj;
    logic at_decide;
    logic at_end;
    logic brk_cond;
    logic push;
    logic pop;
    logic full;
    logic wr_en;

    // Third sample is the live synchroniser output at scnt = 9.
    assign bit_maj   = (samp7_reg & samp8_reg) | (samp7_reg & rx_s_reg) | (samp8_reg & rx_s_reg);
    assign at_decide = (scnt_reg == 4'd9);
    assign at_end    = (scnt_reg == 4'd15);
    assign brk_cond  = (shreg_reg == '0) && ((PARITY == 0) || !par_bit_reg);

    // The push is issued on the stop-bit decision edge so the byte is visible
    // on m_valid/m_data one cycle later.
    assign push = rx_enable && (state_reg == S_STOP) && at_decide && bit_maj && !mismatch_reg;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            rx_meta_reg    <= 1'b1;
            rx_s_reg       <= 1'b1;
            state_reg      <= S_IDLE;
            scnt_reg       <= '0;
            bcnt_reg       <= '0;
            samp7_reg      <= 1'b0;
            samp8_reg      <= 1'b0;
            shreg_reg      <= '0;
            par_bit_reg    <= 1'b0;
            mismatch_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            break_det_reg  <= 1'b0;
        end else begin
            rx_meta_reg    <= rx_in;
            rx_s_reg       <= rx_meta_reg;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            break_det_reg  <= 1'b0;

            if (!rx_enable) begin
                state_reg <= S_IDLE;
                scnt_reg  <= '0;
            end else begin
                if (state_reg != S_IDLE) begin
                    scnt_reg <= scnt_reg + 4'd1;
                    if (scnt_reg == 4'd7) samp7_reg <= rx_s_reg;
                    if (scnt_reg == 4'd8) samp8_reg <= rx_s_reg;
                end

                case (state_reg)
                    S_IDLE: begin
                        if (!rx_s_reg) begin
                            state_reg    <= S_START;
                            scnt_reg     <= 4'd1;
                            mismatch_reg <= 1'b0;
                        end
                    end
                    S_START: begin
                        // A start bit that reads high mid-bit was a glitch.
                        if (at_decide && bit_maj) begin
                            state_reg <= S_IDLE;
                        end else if (at_end) begin
                            state_reg <= S_DATA;
                            bcnt_reg  <= '0;
                        end
                    end
                    S_DATA: begin
                        if (at_decide) shreg_reg[bcnt_reg] <= bit_maj;
                        if (at_end) begin
                            if (bcnt_reg == BW'(DATA_BITS - 1))
                                state_reg <= (PARITY == 0) ? S_STOP : S_PARITY;
                            else
                                bcnt_reg <= bcnt_reg + BW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (at_decide) begin
                            par_bit_reg  <= bit_maj;
                            mismatch_reg <= bit_maj ^ (^shreg_reg) ^ PAR_ODD;
                        end
                        if (at_end) state_reg <= S_STOP;
                    end
                    S_STOP: begin
                        // Leave at mid stop bit so a following start edge is caught early.
                        if (at_decide) begin
                            state_reg <= S_IDLE;
                            scnt_reg  <= '0;
                            if (!bit_maj) begin
                                frame_err_reg <= 1'b1;
                                break_det_reg <= brk_cond;
                            end else if (mismatch_reg) begin
                                parity_err_reg <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    // FIFO
    assign full  = (level_reg == LW'(FIFO_DEPTH));
    assign pop   = m_valid && m_ready;
    assign wr_en = push && (!full || pop);

    // Storage carries no reset; m_data is masked to 0 while empty instead.
    always_ff @(posedge rxclk) begin
        if (wr_en) mem[wr_ptr_reg] <= shreg_reg;
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (wr_en && !pop)      level_reg <= level_reg + LW'(1);
            else if (!wr_en && pop) level_reg <= level_reg - LW'(1);

            if (push && full && !pop) overrun_reg <= 1'b1;
            else if (clr_overrun)     overrun_reg <= 1'b0;
        end
    end

    assign m_valid    = (level_reg != '0);
    assign m_data     = m_valid ? mem[rd_ptr_reg] : '0;
    assign fifo_level = level_reg;
    assign overrun    = overrun_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign break_det  = break_det_reg;

endmodule
